div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
- Iterative radix-2 divider with its sequencing controller for RV32M DIV/DIVU/REM/REMU in the EX stage.
- Accepts one operation from the pipeline and asserts stall while the divide runs.
- Returns a registered result plus destination register address with a one-cycle done pulse.
- Handles divide-by-zero, signed overflow and branch flush.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  EX holds a valid M-extension divide op (opcode Rtype, funct7[0]=1, funct3[2]=1)
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_data  input  XLEN  dividend (forwarded value)
- rs2_data  input  XLEN  divisor (forwarded value)
- rd_addr_in  input  5  destination register of the op
- flush  input  1  branch/jump kill (pc_sel taken)
- stall  output  1  freeze IF/ID/EX pipeline registers
- busy  output  1  FSM not in IDLE
- done  output  1  one-cycle result-valid pulse
- result  output  XLEN  quotient or remainder, sign-corrected
- rd_addr_out  output  5  rd of the completed op

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, sampled on posedge clk only.
- Reset values: state=IDLE, stall=0, busy=0, done=0, result=0, rd_addr_out=0, counter=0, internal quotient/remainder/divisor registers=0.
- Reset mid-operation returns to IDLE on the next edge. No done is produced for the aborted op.
- States: IDLE, CALC, DONE.
- IDLE:
  - Accept when start=1 and flush=0 at edge T.
  - On accept, latch op and rd_addr_in.
  - Latch operand magnitudes: for DIV/REM take the absolute value of signed operands; for DIVU/REMU pass operands through.
  - Record neg_q = sign(rs1)^sign(rs2) and neg_r = sign(rs1), signed ops only.
  - Special cases go IDLE->DONE at T+1:
    - Divisor==0: quotient=all ones, remainder=rs1_data.
    - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
  - Otherwise go to CALC with counter=XLEN-1.
- CALC:
  - Each cycle performs one restoring step: shift {rem,quo} left by 1; if rem>=divisor, subtract and set quo LSB.
  - Remainder path is XLEN+1 bits wide; subtraction is unsigned.
  - Counter decrements each cycle. After the step with counter==0 (XLEN CALC cycles, T+1..T+32), go to DONE.
- DONE, one cycle:
  - done=1.
  - result is registered on entry: REM/REMU select remainder, DIV/DIVU select quotient. Apply two's-complement negation when neg_q (quotient) or neg_r (remainder).
  - rd_addr_out is valid.
  - Next state is IDLE.
- Latency, normal op: start sampled at T, done=1 at T+33. Special-case op: done=1 at T+1.
- stall (combinational):
  - stall = (state==IDLE && start && !flush) || state==CALC.
  - stall is 0 in DONE so the pipeline advances with result in that cycle.
  - start is ignored while state==DONE (the instruction has already been retired).
- busy = (state!=IDLE).
- flush during CALC: abort to IDLE next edge; done never asserts; result and rd_addr_out keep their previous values.
- flush during DONE: ignored; the result is already committed.
- start and flush simultaneously in IDLE: flush wins, no accept, stall=0.
- result and rd_addr_out hold their values until the next DONE entry.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the unsigned magnitude of the dividend is less than that of the divisor (and the divisor is nonzero), skip CALC and go to DONE at T+1 with quotient=0 and remainder=dividend (sign-corrected per neg_r).
- Not defined: every non-special op takes the full XLEN CALC cycles (done at T+33). No extra comparator logic is synthesized.

Test Plan:
- DIVU 100/7 -> stall high T..T+32, done at T+33, result=14. Repeat as REMU -> result=2.
- REM rs1=0xFFFFFFF9 (-7), rs2=2 -> done T+33, result=0xFFFFFFFF (-1). Same operands as DIV -> result=0xFFFFFFFD (-3).
- DIVU 5/0 -> done T+1, result=0xFFFFFFFF. REMU 5/0 -> result=5.
- DIV 0x80000000/0xFFFFFFFF -> done T+1, result=0x80000000. REM same operands -> result=0.
- DIVU 1000/3 with flush=1 at T+10 -> busy=0 at T+11, no done. New start at T+12 with DIVU 9/3 -> done at T+45, result=3, rd_addr_out = rd of the second op.
- DIVU 3/10 -> with DIV_EARLY_OUT_EN, done T+1, result=0. Without it, done T+33, result=0. REMU same operands -> result=3 in both builds.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: iterative radix-2 restoring divider and its sequencing
// controller for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Optional build macro: DIV_EARLY_OUT_EN (skip the iterations when the
// dividend magnitude is below the divisor magnitude).
module div_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_in,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   quo_reg;
    logic [XLEN:0]     rem_reg;
    logic [XLEN-1:0]   div_reg;
    logic              sel_rem_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic [4:0]        rd_reg;
    logic              done_reg;
    logic [XLEN-1:0]   result_reg;
    logic [4:0]        rd_addr_out_reg;

    // Operand decode at accept time
    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              sign_ovf;
    logic              early_out;
    logic              accept;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & rs1_data[XLEN-1];
    assign b_neg     = is_signed & rs2_data[XLEN-1];
    assign a_mag     = a_neg ? (~rs1_data + XLEN'(1)) : rs1_data;
    assign b_mag     = b_neg ? (~rs2_data + XLEN'(1)) : rs2_data;
    assign div_zero  = (rs2_data == '0);
    assign sign_ovf  = is_signed && (rs1_data == SIGN_MIN) && (rs2_data == '1);
    assign accept    = (state_reg == IDLE) && start && !flush;

`ifdef DIV_EARLY_OUT_EN
    // A nonzero divisor larger than the dividend yields quotient 0 directly.
    assign early_out = (a_mag < b_mag);
`else
    assign early_out = 1'b0;
`endif

    // One restoring step: {rem,quo} << 1, then conditional subtract.
    // The extra top bit lets the subtraction borrow serve as the compare.
    logic [XLEN+1:0]   shift_wide;
    logic [XLEN+1:0]   sub_wide;
    logic              ge;
    logic [XLEN:0]     rem_step;
    logic [XLEN-1:0]   quo_step;
    logic [XLEN-1:0]   quo_final;
    logic [XLEN-1:0]   rem_final;

    assign shift_wide = {rem_reg, quo_reg[XLEN-1]};
    assign sub_wide   = shift_wide - {2'b00, div_reg};
    assign ge         = ~sub_wide[XLEN+1];
    assign rem_step   = ge ? sub_wide[XLEN:0] : shift_wide[XLEN:0];
    assign quo_step   = {quo_reg[XLEN-2:0], ge};
    assign quo_final  = neg_q_reg ? (~quo_step + XLEN'(1)) : quo_step;
    assign rem_final  = neg_r_reg ? (~rem_step[XLEN-1:0] + XLEN'(1)) : rem_step[XLEN-1:0];

    // Pipeline freeze while accepting or iterating; released in DONE.
    assign stall       = accept || (state_reg == CALC);
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign result      = result_reg;
    assign rd_addr_out = rd_addr_out_reg;

    // Controller FSM together with the datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            quo_reg         <= '0;
            rem_reg         <= '0;
            div_reg         <= '0;
            sel_rem_reg     <= 1'b0;
            neg_q_reg       <= 1'b0;
            neg_r_reg       <= 1'b0;
            rd_reg          <= '0;
            done_reg        <= 1'b0;
            result_reg      <= '0;
            rd_addr_out_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (accept) begin
                        sel_rem_reg <= op[1];
                        rd_reg      <= rd_addr_in;
                        neg_q_reg   <= a_neg ^ b_neg;
                        neg_r_reg   <= a_neg;
                        quo_reg     <= a_mag;
                        rem_reg     <= '0;
                        div_reg     <= b_mag;
                        cnt_reg     <= CNT_W'(XLEN - 1);
                        if (div_zero) begin
                            state_reg       <= DONE;
                            done_reg        <= 1'b1;
                            result_reg      <= op[1] ? rs1_data : '1;
                            rd_addr_out_reg <= rd_addr_in;
                        end else if (sign_ovf) begin
                            state_reg       <= DONE;
                            done_reg        <= 1'b1;
                            result_reg      <= op[1] ? '0 : SIGN_MIN;
                            rd_addr_out_reg <= rd_addr_in;
                        end else if (early_out) begin
                            // Sign-corrected |dividend| is the dividend itself.
                            state_reg       <= DONE;
                            done_reg        <= 1'b1;
                            result_reg      <= op[1] ? rs1_data : '0;
                            rd_addr_out_reg <= rd_addr_in;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        quo_reg <= quo_step;
                        rem_reg <= rem_step;
                        cnt_reg <= cnt_reg - CNT_W'(1);
                        if (cnt_reg == '0) begin
                            state_reg       <= DONE;
                            done_reg        <= 1'b1;
                            result_reg      <= sel_rem_reg ? rem_final : quo_final;
                            rd_addr_out_reg <= rd_reg;
                        end
                    end
                end
                DONE: begin
                    // start and flush are both ignored here
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed test-plan cases, flush,
// reset and back-to-back handling, plus randomized ops against an
// arithmetic reference model.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_addr_out;

    int checks   = 0;
    int failures = 0;

    div_seq_ctrl #(.XLEN(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rd_addr_in (rd_addr_in),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .rd_addr_out(rd_addr_out)
    );

    always #5 clk = ~clk;

    // RV32M arithmetic result
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        if (!o[0]) begin
            sa = $signed(a);
            sb = $signed(b);
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    // Cycles from the accept cycle to the done cycle
    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        ma = (!o[0] && a[31]) ? (32'd0 - a) : a;
        mb = (!o[0] && b[31]) ? (32'd0 - b) : b;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`else
        if (ma < mb) return 33;
`endif
        return 33;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string name);
        logic [31:0] exp_res;
        logic [31:0] got_res;
        logic [4:0]  got_rd;
        int lat;
        int done_cyc;
        int pulses;
        int stall_cnt;
        int busy_cnt;
        exp_res  = ref_result(o, a, b);
        lat      = ref_latency(o, a, b);
        done_cyc = -1;
        pulses   = 0;
        got_res  = 32'hx;
        got_rd   = 5'hx;
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b0; op = o; rs1_data = a; rs2_data = b; rd_addr_in = rd;
        @(negedge clk);
        stall_cnt = stall ? 1 : 0;
        busy_cnt  = busy ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_addr_in = 5'($urandom);
        for (int n = 1; n <= lat + 2; n++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                pulses++;
                done_cyc = n;
                got_res  = result;
                got_rd   = rd_addr_out;
            end
        end
        $display("op %-14s op=%0d a=%08h b=%08h rd=%0d -> result=%08h rd=%0d done@%0d (exp %08h @%0d)",
                 name, o, a, b, rd, got_res, got_rd, done_cyc, exp_res, lat);
        checks++;
        if (done_cyc !== lat) begin failures++; $display("FAIL %s latency: got %0d expected %0d", name, done_cyc, lat); end
        checks++;
        if (pulses !== 1) begin failures++; $display("FAIL %s done_pulses: got %0d expected 1", name, pulses); end
        checks++;
        if (stall_cnt !== lat) begin failures++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cnt, lat); end
        checks++;
        if (busy_cnt !== lat) begin failures++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, lat); end
        checks++;
        if (got_res !== exp_res) begin failures++; $display("FAIL %s result: got %08h expected %08h", name, got_res, exp_res); end
        checks++;
        if (got_rd !== rd) begin failures++; $display("FAIL %s rd_addr_out: got %0d expected %0d", name, got_rd, rd); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; flush = 1'b0; op = 2'b01;
        rs1_data = 32'd77; rs2_data = 32'd0; rd_addr_in = 5'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("reset: stall=%b busy=%b done=%b result=%08h rd=%0d", stall, busy, done, result, rd_addr_out);
        checks++;
        if ({busy, done, result, rd_addr_out} !== 39'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b result=%08h rd=%0d expected all 0", busy, done, result, rd_addr_out);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset_midop();
        int seen_done;
        int seen_busy;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd7; rd_addr_in = 5'd12;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 0;
        seen_busy = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        $display("reset_midop: done_pulses=%0d busy_cycles=%0d result=%08h", seen_done, seen_busy, result);
        checks++;
        if (seen_done !== 0) begin failures++; $display("FAIL reset_midop_done: got %0d expected 0", seen_done); end
        checks++;
        if (seen_busy !== 0) begin failures++; $display("FAIL reset_midop_busy: got %0d expected 0", seen_busy); end
        checks++;
        if (result !== 32'd0) begin failures++; $display("FAIL reset_midop_result: got %08h expected 00000000", result); end
    endtask

    task automatic test_flush_calc();
        logic [31:0] prev_res;
        logic [4:0]  prev_rd;
        int seen_done;
        prev_res  = result;
        prev_rd   = rd_addr_out;
        seen_done = 0;
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b0; op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr_in = 5'd21;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            flush = (c == 10);
            @(negedge clk);
            if (done) seen_done++;
        end
        $display("flush_calc: busy=%b done_pulses=%0d result=%08h rd=%0d", busy, seen_done, result, rd_addr_out);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b expected 0", busy); end
        checks++;
        if (seen_done !== 0) begin failures++; $display("FAIL flush_done: got %0d expected 0", seen_done); end
        checks++;
        if (result !== prev_res || rd_addr_out !== prev_rd) begin
            failures++;
            $display("FAIL flush_hold: got %08h/%0d expected %08h/%0d", result, rd_addr_out, prev_res, prev_rd);
        end
        run_op(2'b01, 32'd9, 32'd3, 5'd22, "after_flush");
    endtask

    task automatic test_flush_start_idle();
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 2'b01; rs1_data = 32'd8; rs2_data = 32'd2; rd_addr_in = 5'd3;
        @(negedge clk);
        $display("start+flush idle: stall=%b", stall);
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL start_flush_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL start_flush_idle: got busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    // start held through the DONE cycle must be ignored there, then accepted in IDLE
    task automatic test_back_to_back();
        int lat_b;
        int done_cyc;
        logic [31:0] got_res;
        logic [4:0]  got_rd;
        lat_b    = ref_latency(2'b11, 32'd100, 32'd7);
        done_cyc = -1;
        got_res  = 32'hx;
        got_rd   = 5'hx;
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b0; op = 2'b01; rs1_data = 32'd5; rs2_data = 32'd0; rd_addr_in = 5'd3;
        @(posedge clk); #1;
        op = 2'b11; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr_in = 5'd4; flush = 1'b1;
        @(negedge clk);
        $display("b2b first: done=%b stall=%b result=%08h rd=%0d", done, stall, result, rd_addr_out);
        checks++;
        if (done !== 1'b1 || stall !== 1'b0 || result !== 32'hFFFF_FFFF || rd_addr_out !== 5'd3) begin
            failures++;
            $display("FAIL b2b_first: got done=%b stall=%b result=%08h rd=%0d expected 1/0/ffffffff/3",
                     done, stall, result, rd_addr_out);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL b2b_accept_stall: got %b expected 1", stall); end
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= lat_b + 2; n++) begin
            if (n > 1) @(posedge clk);
            @(negedge clk);
            if (done && done_cyc < 0) begin
                done_cyc = n;
                got_res  = result;
                got_rd   = rd_addr_out;
            end
        end
        $display("b2b second: result=%08h rd=%0d done@%0d", got_res, got_rd, done_cyc);
        checks++;
        if (done_cyc !== lat_b || got_res !== 32'd2 || got_rd !== 5'd4) begin
            failures++;
            $display("FAIL b2b_second: got %08h rd=%0d @%0d expected 00000002 rd=4 @%0d", got_res, got_rd, done_cyc, lat_b);
        end
    endtask

    task automatic test_directed();
        run_op(2'b01, 32'd100, 32'd7, 5'd1, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, 5'd2, "remu_100_7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, "rem_m7_2");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4, "div_m7_2");
        run_op(2'b01, 32'd5, 32'd0, 5'd5, "divu_by0");
        run_op(2'b11, 32'd5, 32'd0, 5'd6, "remu_by0");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, "rem_ovf");
        run_op(2'b01, 32'd3, 32'd10, 5'd9, "divu_3_10");
        run_op(2'b11, 32'd3, 32'd10, 5'd10, "remu_3_10");
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd11, "div_7_m2");
        run_op(2'b10, 32'hFFFF_FFFD, 32'hFFFF_FFF6, 5'd13, "rem_m3_m10");
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 300);
                3: a = $urandom_range(0, 50);
                default: ;
            endcase
            run_op(o, a, b, 5'($urandom), "random");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
        rs1_data = 32'd0; rs2_data = 32'd0; rd_addr_in = 5'd0;
        test_reset();
        test_directed();
        test_reset_midop();
        run_op(2'b01, 32'd50, 32'd5, 5'd17, "pre_flush");
        test_flush_calc();
        test_flush_start_idle();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
